n64_scb_req_arbiter: RTL and testbench

Parametrised successor to the fixed per-function pending/done handshake pairs (flashram, rtc, cfg) on the N64 system control bus. Arbitrates NUM_CH requester channels, each with its own level-pending/pulse-done handshake, onto one controller-side handshake. Uses round-robin grant, a per-transaction timeout and a saturating completion counter. Sits between the N64-side request sources (pi, si, flashram) and the controller.

---
 rtl/n64_scb_req_arbiter.sv | 134 +++++++++++++
 tb/tb_n64_scb_req_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_scb_req_arbiter.sv
// Round-robin arbiter folding NUM_CH level-pending/pulse-done requesters onto one
// controller handshake, with per-transaction timeout and a saturating completion count.
module n64_scb_req_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int CMD_W   = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int COUNT_W = 16,
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_pending,
  input  logic [NUM_CH*CMD_W-1:0]    ch_cmd,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_done,
  output logic [NUM_CH-1:0]          ch_error,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       ctl_pending,
  output logic [CH_W-1:0]            ctl_channel,
  output logic [CMD_W-1:0]           ctl_cmd,
  output logic [DATA_W-1:0]          ctl_wdata,
  input  logic                       ctl_done,
  input  logic                       ctl_error,
  input  logic [DATA_W-1:0]          ctl_rdata,
  output logic [COUNT_W-1:0]         done_count
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t              state, state_nxt;
  logic [CH_W-1:0]     last;
  logic [NUM_CH-1:0]   mask;
  logic [NUM_CH-1:0]   eligible;
  logic [NUM_CH-1:0]   onehot;
  logic [TO_W-1:0]     to_cnt;
  logic                err_q;
  logic                grant_vld;
  logic [CH_W-1:0]     grant_ch;
  logic [CH_W:0]       idx;
  logic                timeout_hit;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  assign onehot      = NUM_CH'(1) << ctl_channel;
  assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);

  // Rotating priority search starting just above the last granted channel
  always_comb begin
    eligible  = ch_pending & ~mask;
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, last} + (CH_W+1)'(i + 1);
      if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
      if (!grant_vld && eligible[idx[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ctl_pending = 1'b0;
    ch_done     = '0;
    ch_error    = '0;
    case (state)
      IDLE:   if (grant_vld) state_nxt = ACTIVE;
      ACTIVE: begin
        ctl_pending = 1'b1;
        if (ctl_done || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        ch_done   = onehot;
        ch_error  = onehot & {NUM_CH{err_q}};
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last        <= CH_W'(NUM_CH - 1);
      mask        <= '0;
      to_cnt      <= '0;
      err_q       <= 1'b0;
      ctl_channel <= '0;
      ctl_cmd     <= '0;
      ctl_wdata   <= '0;
      ch_rdata    <= '0;
      done_count  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          mask <= '0;
          if (grant_vld) begin
            ctl_channel <= grant_ch;
            ctl_cmd     <= ch_cmd[grant_ch*CMD_W +: CMD_W];
            ctl_wdata   <= ch_wdata[grant_ch*DATA_W +: DATA_W];
            last        <= grant_ch;
          end
        end
        ACTIVE: begin
          to_cnt <= to_cnt + TO_W'(1);
          // A real completion takes precedence over a timeout landing in the same cycle
          if (ctl_done) begin
            ch_rdata <= ctl_rdata;
            err_q    <= ctl_error;
          end else if (timeout_hit) begin
            ch_rdata <= '0;
            err_q    <= 1'b1;
          end
        end
        DONE: begin
          mask   <= onehot;
          to_cnt <= '0;
          if (!err_q) done_count <= sat_inc(done_count);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_scb_req_arbiter.sv
// Bench for n64_scb_req_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level round-robin model.
module tb_n64_scb_req_arbiter;

  localparam int NCH  = 4;
  localparam int CW   = 8;
  localparam int DW   = 32;
  localparam int TO   = 8;
  localparam int CNTW = 2;
  localparam int CHW  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NCH-1:0]      ch_pending;
  logic [NCH*CW-1:0]   ch_cmd;
  logic [NCH*DW-1:0]   ch_wdata;
  logic [NCH-1:0]      ch_done;
  logic [NCH-1:0]      ch_error;
  logic [DW-1:0]       ch_rdata;
  logic                ctl_pending;
  logic [CHW-1:0]      ctl_channel;
  logic [CW-1:0]       ctl_cmd;
  logic [DW-1:0]       ctl_wdata;
  logic                ctl_done;
  logic                ctl_error;
  logic [DW-1:0]       ctl_rdata;
  logic [CNTW-1:0]     done_count;

  n64_scb_req_arbiter #(
    .NUM_CH(NCH), .CMD_W(CW), .DATA_W(DW), .TIMEOUT(TO), .COUNT_W(CNTW)
  ) dut (
    .clk(clk), .reset(reset),
    .ch_pending(ch_pending), .ch_cmd(ch_cmd), .ch_wdata(ch_wdata),
    .ch_done(ch_done), .ch_error(ch_error), .ch_rdata(ch_rdata),
    .ctl_pending(ctl_pending), .ctl_channel(ctl_channel),
    .ctl_cmd(ctl_cmd), .ctl_wdata(ctl_wdata),
    .ctl_done(ctl_done), .ctl_error(ctl_error), .ctl_rdata(ctl_rdata),
    .done_count(done_count)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Model: last granted channel, channel blocked for one idle cycle, completion count
  int             m_last;
  logic [NCH-1:0] m_mask;
  int             m_count;

  int order[6] = '{0, 2, 3, 0, 2, 3};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = NCH - 1;
    m_mask  = '0;
    m_count = 0;
  endtask

  function automatic int rr_pick(input logic [NCH-1:0] req, input int last);
    for (int d = 1; d <= NCH; d++) begin
      if (req[CHW'((last + d) % NCH)]) return (last + d) % NCH;
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_ctl_pending"}, ctl_pending, 0);
    chk({pfx, "_ch_done"},     ch_done, 0);
    chk({pfx, "_ch_error"},    ch_error, 0);
    chk({pfx, "_ch_rdata"},    ch_rdata, 0);
    chk({pfx, "_ctl_channel"}, ctl_channel, 0);
    chk({pfx, "_ctl_cmd"},     ctl_cmd, 0);
    chk({pfx, "_ctl_wdata"},   ctl_wdata, 0);
    chk({pfx, "_done_count"},  done_count, 0);
  endtask

  // One idle-cycle decision: predicts the grant from current inputs, then checks it
  task automatic grant_cycle(output int g, output logic [CW-1:0] ec, output logic [DW-1:0] ew);
    g  = rr_pick(ch_pending & ~m_mask, m_last);
    ec = '0;
    ew = '0;
    if (g >= 0) begin
      ec = ch_cmd[g*CW +: CW];
      ew = ch_wdata[g*DW +: DW];
    end
    step();
    m_mask = '0;
    if (g >= 0) begin
      m_last = g;
      chk("grant_pending", ctl_pending, 1);
      chk("grant_channel", ctl_channel, g);
      chk("grant_cmd", ctl_cmd, ec);
      chk("grant_wdata", ctl_wdata, ew);
    end else begin
      chk("idle_no_grant", ctl_pending, 0);
    end
  endtask

  task automatic acquire(output int g, output logic [CW-1:0] ec, output logic [DW-1:0] ew);
    g = -1;
    for (int t = 0; t < 6; t++) begin
      grant_cycle(g, ec, ew);
      if (g >= 0) break;
    end
    if (g < 0) chk("acquire_bound", ctl_pending, 1);
  endtask

  // Controller side of one transaction; d > TO means the controller stays silent
  task automatic run_txn(input int ch, input logic [CW-1:0] ec, input logic [DW-1:0] ew,
                         input int d, input logic err, input logic [DW-1:0] rd,
                         input bit drop_mid, input bit scramble, input bit keep,
                         input bit spurious);
    bit            hit = 0;
    logic          e_err;
    logic [DW-1:0] e_rd;
    for (int k = 1; k <= TO; k++) begin
      chk("act_pending", ctl_pending, 1);
      chk("act_channel", ctl_channel, ch);
      chk("act_cmd", ctl_cmd, ec);
      chk("act_wdata", ctl_wdata, ew);
      chk("act_no_done", ch_done, 0);
      if (k == 1 && drop_mid) ch_pending[ch] = 1'b0;
      if (k == 1 && scramble) begin
        ch_cmd[ch*CW +: CW]   = CW'($urandom);
        ch_wdata[ch*DW +: DW] = $urandom;
      end
      if (k == d) begin
        ctl_done  = 1'b1;
        ctl_error = err;
        ctl_rdata = rd;
        hit = 1;
      end
      step();
      ctl_done  = 1'b0;
      ctl_error = 1'($urandom);
      ctl_rdata = $urandom;
      if (hit) break;
    end
    e_err = hit ? err : 1'b1;
    e_rd  = hit ? rd : '0;
    chk("done_onehot", ch_done, 64'(1) << ch);
    chk("done_error", ch_error, e_err ? (64'(1) << ch) : 64'(0));
    chk("done_rdata", ch_rdata, e_rd);
    chk("done_pending_low", ctl_pending, 0);
    if (!e_err && m_count < (1 << CNTW) - 1) m_count++;
    if (!keep) ch_pending[ch] = 1'b0;
    if (spurious) begin
      ctl_done  = 1'b1;
      ctl_error = 1'b0;
    end
    step();
    ctl_done = 1'b0;
    m_mask   = NCH'(1) << ch;
    chk("done_count", done_count, m_count);
    chk("done_single_pulse", ch_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int             g;
    logic [CW-1:0]  ec;
    logic [DW-1:0]  ew;
    int             ntx;
    bit             stale_p;
    int             stale_c;
    bit             keep;

    reset = 1'b1;
    ch_pending = '0; ch_cmd = '0; ch_wdata = '0;
    ctl_done = 1'b0; ctl_error = 1'b0; ctl_rdata = '0;
    model_reset();
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;

    // Single request on channel 1
    ch_pending[1] = 1'b1;
    ch_cmd[15:8] = 8'h5A;
    ch_wdata[63:32] = 32'hDEADBEEF;
    grant_cycle(g, ec, ew);
    chk("single_channel", ctl_channel, 1);
    chk("single_cmd", ctl_cmd, 8'h5A);
    run_txn(g, ec, ew, 4, 1'b0, 32'h12345678, 0, 0, 0, 0);
    chk("single_count", done_count, 1);

    // Controller completion while idle is ignored
    ctl_done = 1'b1; ctl_error = 1'b0;
    grant_cycle(g, ec, ew);
    ctl_done = 1'b0;
    step();
    chk("idle_done_count", done_count, m_count);
    chk("idle_done_no_pulse", ch_done, 0);

    // Round-robin among channels 0, 2, 3 held continuously
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < NCH; c++) begin
      ch_cmd[c*CW +: CW]   = CW'(8'h10 + c);
      ch_wdata[c*DW +: DW] = 32'hA000_0000 + c;
    end
    ch_pending = 4'b1101;
    for (int i = 0; i < 6; i++) begin
      acquire(g, ec, ew);
      chk("rr_order", ctl_channel, order[i]);
      run_txn(g, ec, ew, 2, 1'b0, $urandom, 0, 0, 1, 0);
    end
    ch_pending = '0;

    // Stale pending on channel 0 for one cycle after its completion
    ch_pending[0] = 1'b1;
    acquire(g, ec, ew);
    run_txn(g, ec, ew, 3, 1'b0, $urandom, 0, 0, 1, 0);
    grant_cycle(g, ec, ew);
    chk("stale_masked", ctl_pending, 0);
    ch_pending[0] = 1'b0;
    grant_cycle(g, ec, ew);

    // Timeout with a silent controller
    ch_pending[2] = 1'b1;
    acquire(g, ec, ew);
    run_txn(g, ec, ew, TO + 1, 1'b0, $urandom, 0, 0, 0, 1);

    // Completion on the same cycle the timeout would fire
    ch_pending[2] = 1'b1;
    acquire(g, ec, ew);
    run_txn(g, ec, ew, TO, 1'b0, 32'hCAFE_F00D, 0, 0, 0, 0);

    // Reset on the third active cycle
    ch_pending = 4'b1010;
    acquire(g, ec, ew);
    step();
    step();
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    step();
    chk("midreset_no_done", ch_done, 0);
    reset = 1'b0;
    model_reset();
    acquire(g, ec, ew);
    chk("reset_lowest", ctl_channel, 1);
    ch_pending[3] = 1'b0;
    run_txn(g, ec, ew, 3, 1'b0, $urandom, 0, 0, 0, 0);

    // Saturation: five error-free completions since reset
    for (int i = 0; i < 4; i++) begin
      ch_pending[1] = 1'b1;
      acquire(g, ec, ew);
      run_txn(g, ec, ew, 1, 1'b0, $urandom, 0, 0, 0, 0);
    end
    chk("saturated_count", done_count, 3);

    // Randomized traffic
    ntx = 0;
    stale_p = 0;
    stale_c = 0;
    for (int it = 0; it < 1000 && ntx < 60; it++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!ch_pending[c] && $urandom_range(0, 2) == 0) begin
          ch_pending[c] = 1'b1;
          ch_cmd[c*CW +: CW]   = CW'($urandom);
          ch_wdata[c*DW +: DW] = $urandom;
        end
      end
      grant_cycle(g, ec, ew);
      if (stale_p) begin
        ch_pending[stale_c] = 1'b0;
        stale_p = 0;
      end
      if (g < 0) continue;
      keep = ($urandom_range(0, 3) == 0);
      run_txn(g, ec, ew, $urandom_range(1, 10), 1'($urandom), $urandom,
              $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, keep,
              $urandom_range(0, 3) == 0);
      if (keep) begin
        stale_p = 1;
        stale_c = g;
      end
      ntx++;
    end
    chk("random_txn_count", 64'(ntx), 60);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
